regfile_write_arbiter: RTL



---
 rtl/regfile_write_arbiter.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/regfile_write_arbiter.sv
// Shares the register file write port between the writeback stage and a one-entry long-latency result buffer, with bounded-wait forcing and x0 filtering.
// Optional: define REGFILE_WAW_SQUASH_EN so that a WB write to the buffered register drops the older buffered value (default: drain LL first, then WB).
module regfile_write_arbiter #(
   parameter int BIT_COUNT      = 32,
   parameter int REGISTER_COUNT = 32,
   parameter int MAX_WAIT       = 4
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              WbValid,
   input  logic [$clog2(REGISTER_COUNT)-1:0] WbAdr,
   input  logic [BIT_COUNT-1:0]              WbData,
   output logic                              WbReady,
   input  logic                              LlValid,
   input  logic [$clog2(REGISTER_COUNT)-1:0] LlAdr,
   input  logic [BIT_COUNT-1:0]              LlData,
   output logic                              LlReady,
   output logic                              WriteEnable,
   output logic [$clog2(REGISTER_COUNT)-1:0] rd1Adr,
   output logic [BIT_COUNT-1:0]              Rd1,
   output logic                              LlPending
);

   localparam int ADR_W  = $clog2(REGISTER_COUNT);
   localparam int WAIT_W = $clog2(MAX_WAIT + 1);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] HELD  = 2'd1;
   localparam logic [1:0] FORCE = 2'd2;

   logic [1:0]           state_q,   state_d;
   logic [WAIT_W-1:0]    wait_q,    wait_d;
   logic [ADR_W-1:0]     buf_adr_q, buf_adr_d;
   logic [BIT_COUNT-1:0] buf_dat_q, buf_dat_d;

   logic                 sel_wb;
   logic                 sel_buf;
   logic                 wb_ready;
   logic                 conflict;
   logic [ADR_W-1:0]     wr_adr;
   logic [BIT_COUNT-1:0] wr_dat;
   logic                 wr_en;

   assign conflict = (state_q == HELD) && WbValid &&
                     (WbAdr == buf_adr_q) && (WbAdr != '0);

   always_comb begin
      state_d   = state_q;
      wait_d    = wait_q;
      buf_adr_d = buf_adr_q;
      buf_dat_d = buf_dat_q;
      sel_wb    = 1'b0;
      sel_buf   = 1'b0;
      wb_ready  = 1'b1;
      case (state_q)
         IDLE: begin
            sel_wb = WbValid;
            if (LlValid) begin
               buf_adr_d = LlAdr;
               buf_dat_d = LlData;
               wait_d    = '0;
               state_d   = HELD;
            end
         end
         HELD: begin
            if (conflict) begin
`ifdef REGFILE_WAW_SQUASH_EN
               // Younger WB value wins; the buffered entry is discarded unwritten.
               sel_wb  = 1'b1;
`else
               // Older LL value goes first; WB retries next cycle.
               wb_ready = 1'b0;
               sel_buf  = 1'b1;
`endif
               wait_d  = '0;
               state_d = IDLE;
            end else if (!WbValid) begin
               sel_buf = 1'b1;
               wait_d  = '0;
               state_d = IDLE;
            end else begin
               sel_wb = 1'b1;
               if (wait_q == WAIT_W'(MAX_WAIT - 1)) begin
                  state_d = FORCE;
               end else begin
                  wait_d = wait_q + WAIT_W'(1);
               end
            end
         end
         FORCE: begin
            wb_ready = 1'b0;
            sel_buf  = 1'b1;
            wait_d   = '0;
            state_d  = IDLE;
         end
         default: begin
            wait_d  = '0;
            state_d = IDLE;
         end
      endcase
   end

   assign wr_adr = sel_buf ? buf_adr_q : WbAdr;
   assign wr_dat = sel_buf ? buf_dat_q : WbData;
   // x0 writes still complete their handshake/drain but never strobe the file.
   assign wr_en  = (sel_wb || sel_buf) && (wr_adr != '0);

   assign WriteEnable = wr_en;
   assign rd1Adr      = wr_en ? wr_adr : '0;
   assign Rd1         = wr_en ? wr_dat : '0;
   assign WbReady     = wb_ready;
   assign LlReady     = (state_q == IDLE);
   assign LlPending   = (state_q != IDLE);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         wait_q    <= '0;
         buf_adr_q <= '0;
         buf_dat_q <= '0;
      end else begin
         state_q   <= state_d;
         wait_q    <= wait_d;
         buf_adr_q <= buf_adr_d;
         buf_dat_q <= buf_dat_d;
      end
   end

`ifndef SYNTHESIS
   a_force_one_cycle: assert property (@(posedge clk) disable iff (!reset)
      (state_q == FORCE) |=> (state_q == IDLE));
   a_wait_bounded: assert property (@(posedge clk) disable iff (!reset)
      int'(wait_q) < MAX_WAIT);
   a_no_x0_write: assert property (@(posedge clk) disable iff (!reset)
      WriteEnable |-> (rd1Adr != '0));
   a_state_legal: assert property (@(posedge clk) disable iff (!reset)
      state_q != 2'd3);
`endif

endmodule
